// File: rtl/sc_game_pkg.sv
// sc_game_pkg: board width, player FSM states and one-hot helper shared by the game blocks
package sc_game_pkg;
  localparam int BOARD_WIDTH = 8;
  typedef enum logic [1:0] {PLAY = 2'd0, HIT = 2'd1, RESPAWN = 2'd2} state_t;
  function automatic logic [63:0] oneHot(input int idx);
    return 64'd1 << idx;
  endfunction
endpackage

// File: rtl/sc_posjug2_shifter_if.sv
// sc_posjug2_shifter_if: button/tick/hit inputs and position/blink/restart outputs of the player-2 shifter
interface sc_posjug2_shifter_if #(parameter int DATAWIDTH = sc_game_pkg::BOARD_WIDTH);
  logic SC_POSJUG2_btnLeft_In;
  logic SC_POSJUG2_btnRight_In;
  logic SC_POSJUG2_tick_In;
  logic SC_POSJUG2_hit_In;
  logic [DATAWIDTH-1:0] SC_POSJUG2_posjug2_OutBUS;
  logic SC_POSJUG2_blank_Out;
  logic SC_POSJUG2_restart_Out;
  modport master (
    output SC_POSJUG2_btnLeft_In, SC_POSJUG2_btnRight_In, SC_POSJUG2_tick_In, SC_POSJUG2_hit_In,
    input  SC_POSJUG2_posjug2_OutBUS, SC_POSJUG2_blank_Out, SC_POSJUG2_restart_Out
  );
  modport slave (
    input  SC_POSJUG2_btnLeft_In, SC_POSJUG2_btnRight_In, SC_POSJUG2_tick_In, SC_POSJUG2_hit_In,
    output SC_POSJUG2_posjug2_OutBUS, SC_POSJUG2_blank_Out, SC_POSJUG2_restart_Out
  );
endinterface

// File: rtl/sc_edge_detect.sv
// sc_edge_detect: rising-edge detector; previous value resets to 1 so a level held through reset is not an edge
module sc_edge_detect (
  input  logic clk,
  input  logic rstN,
  input  logic btn,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) prev <= 1'b1;
    else prev <= btn;
  assign rise = btn & ~prev;
endmodule

// File: rtl/sc_posjug2_shifter.sv
// sc_posjug2_shifter: one-hot player-2 position driven by button edges, frozen and blinking after a collision
module sc_posjug2_shifter
  import sc_game_pkg::*;
#(
  parameter int DATAWIDTH   = BOARD_WIDTH,
  parameter int START_INDEX = 4,
  parameter int HIT_TICKS   = 6
) (
  input  logic SC_POSJUG2_CLOCK_50,
  input  logic SC_POSJUG2_RESET_InLow,
  sc_posjug2_shifter_if.slave bus
);
  localparam int CW = $clog2(HIT_TICKS + 1);
  localparam logic [63:0] START_WIDE = oneHot(START_INDEX);
  localparam logic [DATAWIDTH-1:0] START_POS = START_WIDE[DATAWIDTH-1:0];
  logic clk, rstN, riseL, riseR, pendL, pendR, blank, restart;
  logic [DATAWIDTH-1:0] pos;
  logic [CW-1:0] cnt;
  state_t state;
  assign clk  = SC_POSJUG2_CLOCK_50;
  assign rstN = SC_POSJUG2_RESET_InLow;
  sc_edge_detect edgeL (.clk(clk), .rstN(rstN), .btn(bus.SC_POSJUG2_btnLeft_In),  .rise(riseL));
  sc_edge_detect edgeR (.clk(clk), .rstN(rstN), .btn(bus.SC_POSJUG2_btnRight_In), .rise(riseR));
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= PLAY;
      pos     <= START_POS;
      cnt     <= '0;
      pendL   <= 1'b0;
      pendR   <= 1'b0;
      blank   <= 1'b0;
      restart <= 1'b0;
    end else begin
      restart <= 1'b0;
      case (state)
        PLAY:
          if (bus.SC_POSJUG2_hit_In) begin
            state <= HIT;
            cnt   <= CW'(HIT_TICKS);
            pendL <= 1'b0;
            pendR <= 1'b0;
          end else if (bus.SC_POSJUG2_tick_In) begin
            // saturating move; an edge seen on this tick waits for the next one
            if (pendL && !pendR && !pos[DATAWIDTH-1]) pos <= pos << 1;
            else if (pendR && !pendL && !pos[0]) pos <= pos >> 1;
            pendL <= riseL;
            pendR <= riseR;
          end else begin
            pendL <= pendL | riseL;
            pendR <= pendR | riseR;
          end
        HIT:
          if (bus.SC_POSJUG2_tick_In) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state   <= RESPAWN;
              pos     <= START_POS;
              blank   <= 1'b0;
              restart <= 1'b1;
            end else blank <= ~blank;
          end
        default: state <= PLAY;
      endcase
    end
  end
  assign bus.SC_POSJUG2_posjug2_OutBUS = pos;
  assign bus.SC_POSJUG2_blank_Out      = blank;
  assign bus.SC_POSJUG2_restart_Out    = restart;
endmodule

// File: tb/tb_sc_posjug2_shifter.sv
// tb_sc_posjug2_shifter: directed checks of moves, saturation, collision freeze/blink, respawn and reset abort
module tb_sc_posjug2_shifter;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sc_posjug2_shifter_if #(.DATAWIDTH(8)) bus ();
  sc_posjug2_shifter #(.DATAWIDTH(8), .START_INDEX(4), .HIT_TICKS(6)) dut (
    .SC_POSJUG2_CLOCK_50(clk),
    .SC_POSJUG2_RESET_InLow(rstN),
    .bus(bus)
  );
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chkOut(input string tag, input logic [7:0] pos, input logic blank, input logic restart);
    chk({tag, " pos"}, bus.SC_POSJUG2_posjug2_OutBUS, pos);
    chk({tag, " blank"}, {7'b0, bus.SC_POSJUG2_blank_Out}, {7'b0, blank});
    chk({tag, " restart"}, {7'b0, bus.SC_POSJUG2_restart_Out}, {7'b0, restart});
  endtask
  task automatic press(input logic l, input logic r);
    bus.SC_POSJUG2_btnLeft_In = l;
    bus.SC_POSJUG2_btnRight_In = r;
    cyc(1);
    bus.SC_POSJUG2_btnLeft_In = 1'b0;
    bus.SC_POSJUG2_btnRight_In = 1'b0;
    bus.SC_POSJUG2_tick_In = 1'b1;
    cyc(1);
    bus.SC_POSJUG2_tick_In = 1'b0;
    cyc(1);
  endtask
  task automatic tickOnly();
    bus.SC_POSJUG2_tick_In = 1'b1;
    cyc(1);
    bus.SC_POSJUG2_tick_In = 1'b0;
    cyc(1);
  endtask
  initial begin
    bus.SC_POSJUG2_btnLeft_In = 1'b0;
    bus.SC_POSJUG2_btnRight_In = 1'b0;
    bus.SC_POSJUG2_tick_In = 1'b0;
    bus.SC_POSJUG2_hit_In = 1'b0;
    cyc(2);
    chkOut("reset", 8'b0001_0000, 1'b0, 1'b0);
    rstN = 1'b1;
    cyc(1);
    press(1'b0, 1'b1);
    chkOut("right move", 8'b0000_1000, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      bus.SC_POSJUG2_btnLeft_In = 1'b1;
      bus.SC_POSJUG2_tick_In = (i % 10 == 5);
      cyc(1);
    end
    bus.SC_POSJUG2_btnLeft_In = 1'b0;
    bus.SC_POSJUG2_tick_In = 1'b0;
    cyc(1);
    chk("held left one move", bus.SC_POSJUG2_posjug2_OutBUS, 8'b0001_0000);
    press(1'b1, 1'b0);
    chk("left 1", bus.SC_POSJUG2_posjug2_OutBUS, 8'b0010_0000);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("left to msb", bus.SC_POSJUG2_posjug2_OutBUS, 8'b1000_0000);
    press(1'b1, 1'b0);
    chk("left saturate", bus.SC_POSJUG2_posjug2_OutBUS, 8'b1000_0000);
    tickOnly();
    chk("saturated request consumed", bus.SC_POSJUG2_posjug2_OutBUS, 8'b1000_0000);
    press(1'b0, 1'b1);
    chk("right from msb", bus.SC_POSJUG2_posjug2_OutBUS, 8'b0100_0000);
    press(1'b1, 1'b1);
    chk("both no move", bus.SC_POSJUG2_posjug2_OutBUS, 8'b0100_0000);
    tickOnly();
    chk("both flags cleared", bus.SC_POSJUG2_posjug2_OutBUS, 8'b0100_0000);
    bus.SC_POSJUG2_btnRight_In = 1'b1;
    bus.SC_POSJUG2_tick_In = 1'b1;
    cyc(1);
    bus.SC_POSJUG2_btnRight_In = 1'b0;
    bus.SC_POSJUG2_tick_In = 1'b0;
    chk("edge with tick deferred", bus.SC_POSJUG2_posjug2_OutBUS, 8'b0100_0000);
    cyc(1);
    tickOnly();
    chk("deferred edge applied", bus.SC_POSJUG2_posjug2_OutBUS, 8'b0010_0000);
    bus.SC_POSJUG2_btnLeft_In = 1'b1;
    cyc(1);
    bus.SC_POSJUG2_btnLeft_In = 1'b0;
    bus.SC_POSJUG2_tick_In = 1'b1;
    bus.SC_POSJUG2_hit_In = 1'b1;
    cyc(1);
    bus.SC_POSJUG2_tick_In = 1'b0;
    bus.SC_POSJUG2_hit_In = 1'b0;
    chkOut("hit entry", 8'b0010_0000, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      bus.SC_POSJUG2_btnLeft_In = 1'b1;
      bus.SC_POSJUG2_hit_In = 1'b1;
      cyc(1);
      bus.SC_POSJUG2_btnLeft_In = 1'b0;
      bus.SC_POSJUG2_hit_In = 1'b0;
      bus.SC_POSJUG2_tick_In = 1'b1;
      cyc(1);
      bus.SC_POSJUG2_tick_In = 1'b0;
      if (i < 6) chkOut($sformatf("hit tick %0d", i), 8'b0010_0000, i[0], 1'b0);
      else chkOut("respawn", 8'b0001_0000, 1'b0, 1'b1);
    end
    cyc(1);
    chkOut("after respawn", 8'b0001_0000, 1'b0, 1'b0);
    tickOnly();
    chk("hit presses discarded", bus.SC_POSJUG2_posjug2_OutBUS, 8'b0001_0000);
    press(1'b0, 1'b1);
    chk("play resumed", bus.SC_POSJUG2_posjug2_OutBUS, 8'b0000_1000);
    bus.SC_POSJUG2_hit_In = 1'b1;
    cyc(1);
    bus.SC_POSJUG2_hit_In = 1'b0;
    tickOnly();
    tickOnly();
    tickOnly();
    chkOut("hit 3 ticks", 8'b0000_1000, 1'b1, 1'b0);
    bus.SC_POSJUG2_btnLeft_In = 1'b1;
    rstN = 1'b0;
    #1;
    chkOut("async reset mid hit", 8'b0001_0000, 1'b0, 1'b0);
    cyc(1);
    rstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.SC_POSJUG2_tick_In = (i % 2 == 1);
      cyc(1);
      chk($sformatf("no restart after reset %0d", i), {7'b0, bus.SC_POSJUG2_restart_Out}, 8'd0);
    end
    bus.SC_POSJUG2_tick_In = 1'b0;
    chk("held through reset no move", bus.SC_POSJUG2_posjug2_OutBUS, 8'b0001_0000);
    bus.SC_POSJUG2_btnLeft_In = 1'b0;
    cyc(1);
    press(1'b1, 1'b0);
    chk("play after reset", bus.SC_POSJUG2_posjug2_OutBUS, 8'b0010_0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
